instr_encoder: RTL

//  Encoder counterpart to the control unit's decode path. It accepts decoded

---
 rtl/instr_encoder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded operation requests into 32-bit instruction
// words, buffers them in a small FIFO and streams each word with its byte
// address to the instruction-memory loader.
module instr_encoder #(
   parameter int unsigned       DEPTH     = 4,
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [3:0]              in_alu_op,
   input  logic                    in_imm_signal,
   input  logic [4:0]              in_rs,
   input  logic [4:0]              in_rt,
   input  logic [4:0]              in_rd,
   input  logic [4:0]              in_shamt,
   input  logic [15:0]             in_imm,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_instr,
   output logic [ADDR_W-1:0]       out_addr,
   output logic                    err_illegal,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_SLL = 4'b1110;
   localparam logic [3:0] OP_SRL = 4'b1100;

   logic [31:0]       r_instr_mem [DEPTH];
   logic [ADDR_W-1:0] r_addr_mem  [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [ADDR_W-1:0] r_next_addr;
   logic              r_err;

   logic [5:0]        w_funct;
   logic [4:0]        w_shamt;
   logic              w_legal;
   logic [31:0]       w_word;
   logic              w_accept;
   logic              w_push;
   logic              w_pop;

   // Encode the current request and classify it as legal or illegal
   always_comb begin
      w_funct = '0;
      w_shamt = '0;
      w_legal = 1'b1;
      w_word  = '0;
      case (in_alu_op)
         OP_ADD:  w_funct = 6'b100000;
         OP_SUB:  w_funct = 6'b100010;
         OP_AND:  w_funct = 6'b100100;
         OP_OR:   w_funct = 6'b100101;
         OP_SLL:  begin w_funct = 6'b000000; w_shamt = in_shamt; end
         OP_SRL:  begin w_funct = 6'b000010; w_shamt = in_shamt; end
         default: w_legal = 1'b0;
      endcase
      if (in_imm_signal) begin
         w_legal = (in_alu_op == OP_ADD);
         w_word  = {6'b111111, in_rs, in_rt, in_imm};
      end else begin
         w_word  = {6'b000000, in_rs, in_rt, in_rd, w_shamt, w_funct};
      end
   end

   assign in_ready  = (r_count != CNT_W'(DEPTH));
   assign out_valid = (r_count != '0);
   assign w_accept  = in_valid & in_ready;
   assign w_push    = w_accept & w_legal;
   assign w_pop     = out_valid & out_ready;

   assign out_instr   = r_instr_mem[r_rd_ptr];
   assign out_addr    = r_addr_mem[r_rd_ptr];
   assign err_illegal = r_err;
   assign count       = r_count;

   // FIFO storage and pointers; head entry drives the outputs directly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_instr_mem[i] <= '0;
            r_addr_mem[i]  <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_instr_mem[r_wr_ptr] <= w_word;
            r_addr_mem[r_wr_ptr]  <= r_next_addr;
            r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
      end
   end

   // Occupancy count; simultaneous push and pop leave it unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Byte address counter, advances only when a word is stored
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_next_addr <= BASE_ADDR;
      end else if (w_push) begin
         r_next_addr <= r_next_addr + ADDR_W'(4);
      end
   end

   // One-cycle pulse after an illegal request is accepted and dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_accept & ~w_legal;
      end
   end

endmodule
